// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for an external pipelined 8-point real-input FFT core: fill, wait latency, drain bins.
// Optional build macro FFT8_FRAME_SCALE_EN: captured bins are arithmetic-shifted right by 3 before storage.
module fft8_frame_ctrl #(
   parameter int DW       = 32,
   parameter int CORE_LAT = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   output logic [8*DW-1:0] core_in,
   input  logic [8*DW-1:0] core_out_r,
   input  logic [8*DW-1:0] core_out_i,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_r,
   output logic [DW-1:0]   out_i,
   output logic [2:0]      out_idx,
   output logic            out_last,
   output logic            busy,
   output logic            frame_done
);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [3:0] LAT = 4'(CORE_LAT);

   state_t        state_reg;
   logic [2:0]    wr_ptr_reg;
   logic [2:0]    rd_ptr_reg;
   logic [3:0]    cnt_reg;
   logic [DW-1:0] buf_reg   [8];
   logic [DW-1:0] res_r_reg [8];
   logic [DW-1:0] res_i_reg [8];
   logic [DW-1:0] cap_r     [8];
   logic [DW-1:0] cap_i     [8];
   logic          in_ready_reg;
   logic          out_valid_reg;
   logic          busy_reg;
   logic          frame_done_reg;
   logic          in_fire;
   logic          out_fire;

   // Frame buffer feeds the core directly; it only changes on sample writes.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         assign core_in[gi*DW +: DW] = buf_reg[gi];
`ifdef FFT8_FRAME_SCALE_EN
         assign cap_r[gi] = DW'($signed(core_out_r[gi*DW +: DW]) >>> 3);
         assign cap_i[gi] = DW'($signed(core_out_i[gi*DW +: DW]) >>> 3);
`else
         assign cap_r[gi] = core_out_r[gi*DW +: DW];
         assign cap_i[gi] = core_out_i[gi*DW +: DW];
`endif
      end
   endgenerate

   assign in_fire  = in_valid & in_ready_reg;
   assign out_fire = out_valid_reg & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= FILL;
         wr_ptr_reg     <= 3'd0;
         rd_ptr_reg     <= 3'd0;
         cnt_reg        <= 4'd0;
         in_ready_reg   <= 1'b1;
         out_valid_reg  <= 1'b0;
         busy_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
         for (int k = 0; k < 8; k++) begin
            buf_reg[k]   <= '0;
            res_r_reg[k] <= '0;
            res_i_reg[k] <= '0;
         end
      end else begin
         frame_done_reg <= 1'b0;
         case (state_reg)
            FILL: begin
               if (in_fire) begin
                  buf_reg[wr_ptr_reg] <= in_data;
                  wr_ptr_reg          <= wr_ptr_reg + 3'd1;
                  if (wr_ptr_reg == 3'd7) begin
                     cnt_reg      <= LAT;
                     state_reg    <= WAIT;
                     in_ready_reg <= 1'b0;
                     busy_reg     <= 1'b1;
                  end
               end
            end
            WAIT: begin
               // Capture one edge after the counter reaches zero, giving the core CORE_LAT full cycles.
               if (cnt_reg == 4'd0) begin
                  for (int k = 0; k < 8; k++) begin
                     res_r_reg[k] <= cap_r[k];
                     res_i_reg[k] <= cap_i[k];
                  end
                  rd_ptr_reg    <= 3'd0;
                  state_reg     <= DRAIN;
                  out_valid_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            DRAIN: begin
               if (out_fire) begin
                  rd_ptr_reg <= rd_ptr_reg + 3'd1;
                  if (rd_ptr_reg == 3'd7) begin
                     state_reg      <= FILL;
                     out_valid_reg  <= 1'b0;
                     busy_reg       <= 1'b0;
                     in_ready_reg   <= 1'b1;
                     frame_done_reg <= 1'b1;
                  end
               end
            end
            default: begin
               state_reg <= FILL;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_reg;
   assign out_valid  = out_valid_reg;
   assign busy       = busy_reg;
   assign frame_done = frame_done_reg;
   assign out_idx    = rd_ptr_reg;
   assign out_last   = out_valid_reg & (rd_ptr_reg == 3'd7);
   assign out_r      = res_r_reg[rd_ptr_reg];
   assign out_i      = res_i_reg[rd_ptr_reg];

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Bench for fft8_frame_ctrl: behavioural 3-stage DFT core, directed frames, scoreboard of expected bins.
module tb_fft8_frame_ctrl;

   localparam int DW       = 32;
   localparam int CORE_LAT = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [31:0]    in_data = '0;
   logic [255:0]   core_in;
   logic [255:0]   core_out_r;
   logic [255:0]   core_out_i;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [31:0]    out_r;
   logic [31:0]    out_i;
   logic [2:0]     out_idx;
   logic           out_last;
   logic           busy;
   logic           frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] r;
      logic [31:0] i;
      logic [2:0]  idx;
   } sb_t;
   sb_t sb[$];

   fft8_frame_ctrl #(.DW(DW), .CORE_LAT(CORE_LAT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .core_in(core_in), .core_out_r(core_out_r), .core_out_i(core_out_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_r(out_r), .out_i(out_i), .out_idx(out_idx), .out_last(out_last),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Reference DFT with Q16.16 twiddles, truncating each product.
   function automatic longint tw(input int m, input bit s);
      longint c [8] = '{65536, 46341, 0, -46341, -65536, -46341, 0, 46341};
      longint sn[8] = '{0, 46341, 65536, 46341, 0, -46341, -65536, -46341};
      return s ? sn[m] : c[m];
   endfunction

   function automatic logic [255:0] dft(input logic [255:0] f, input bit imag);
      logic [255:0] res;
      longint acc;
      longint x;
      res = '0;
      for (int k = 0; k < 8; k++) begin
         acc = 0;
         for (int n = 0; n < 8; n++) begin
            x = longint'($signed(f[n*32 +: 32]));
            if (imag) acc = acc - ((x * tw((k*n) % 8, 1'b1)) >>> 16);
            else      acc = acc + ((x * tw((k*n) % 8, 1'b0)) >>> 16);
         end
         res[k*32 +: 32] = acc[31:0];
      end
      return res;
   endfunction

   // Core model: three registered stages.
   logic [255:0] s1_r, s1_i, s2_r, s2_i, s3_r, s3_i;
   always @(posedge clk) begin
      s1_r <= dft(core_in, 1'b0);
      s1_i <= dft(core_in, 1'b1);
      s2_r <= s1_r;
      s2_i <= s1_i;
      s3_r <= s2_r;
      s3_i <= s2_i;
   end
   assign core_out_r = s3_r;
   assign core_out_i = s3_i;

   function automatic logic [31:0] sc(input logic [31:0] v);
`ifdef FFT8_FRAME_SCALE_EN
      return 32'($signed(v) >>> 3);
`else
      return v;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) chk("ready_valid_excl", 32'(in_ready & out_valid), 32'd0);
   end

   task automatic send_sample(input logic [31:0] d, input bit presented);
      int guard;
      guard = 0;
      if (!presented) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = d;
      end
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
   endtask

   task automatic send_frame(input logic [255:0] f, input logic [255:0] er, input logic [255:0] ei,
                             input bit first_presented, input bit hold_valid);
      int  lat;
      sb_t e;
      for (int s = 0; s < 8; s++) send_sample(f[s*32 +: 32], first_presented && s == 0);
      for (int k = 0; k < 8; k++) begin
         e.r   = sc(er[k*32 +: 32]);
         e.i   = sc(ei[k*32 +: 32]);
         e.idx = 3'(k);
         sb.push_back(e);
      end
      @(negedge clk);
      lat = 1;
      if (hold_valid) in_data = 32'hDEADBEEF;
      else            in_valid = 1'b0;
      chk("busy_wait", 32'(busy), 32'd1);
      chk("in_ready_wait", 32'(in_ready), 32'd0);
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(CORE_LAT + 2));
      $display("[TB] frame sent %h, first bin after %0d cycles", f, lat);
   endtask

   task automatic drain(input bit bp, input int nbins, input bit has_next, input logic [31:0] next_d);
      int          n, cyc, guard;
      bit          held;
      logic [31:0] hr, hi;
      logic [2:0]  hx;
      sb_t         e;
      logic [3:0]  pat;
      n = 0; cyc = 0; guard = 0; held = 1'b0;
      hr = '0; hi = '0; hx = '0;
      pat = 4'b1001;
      while (n < nbins && guard < 200) begin
         @(negedge clk);
         guard++;
         if (held) begin
            chk("hold_r", out_r, hr);
            chk("hold_i", out_i, hi);
            chk("hold_idx", 32'(out_idx), 32'(hx));
            held = 1'b0;
         end
         out_ready = 1'b0;
         if (out_valid) begin
            if (!bp || pat[cyc % 4]) begin
               out_ready = 1'b1;
               if (sb.size() == 0) begin
                  chk("sb_empty", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("bin_r", out_r, e.r);
                  chk("bin_i", out_i, e.i);
                  chk("bin_idx", 32'(out_idx), 32'(e.idx));
                  chk("bin_last", 32'(out_last), 32'(e.idx == 3'd7));
                  $display("[TB] bin %0d r=%h i=%h last=%0d", out_idx, out_r, out_i, out_last);
               end
               n++;
            end else begin
               held = 1'b1;
               hr = out_r; hi = out_i; hx = out_idx;
            end
            cyc++;
         end
      end
      if (n < nbins) chk("drain_timeout", 32'(n), 32'(nbins));
      @(negedge clk);
      out_ready = 1'b0;
      if (nbins == 8) begin
         chk("frame_done", 32'(frame_done), 32'd1);
         chk("in_ready_after", 32'(in_ready), 32'd1);
         chk("out_valid_after", 32'(out_valid), 32'd0);
         chk("sb_drained", 32'(sb.size()), 32'd0);
         if (has_next) begin
            in_valid = 1'b1;
            in_data  = next_d;
         end else begin
            in_valid = 1'b0;
            @(negedge clk);
            chk("frame_done_pulse", 32'(frame_done), 32'd0);
         end
      end
   endtask

   initial begin
      logic [255:0] f_imp, f_dc, f_sh, f_rnd, er, ei, zero;
      zero  = '0;
      f_imp = 256'h00010000;
      f_dc  = {8{32'h00010000}};
      f_sh  = 256'h00010000 << 32;
      f_rnd = '0;
      for (int k = 0; k < 8; k++)
         f_rnd[k*32 +: 32] = 32'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_out_r", out_r, 32'd0);
      chk("rst_out_idx", 32'(out_idx), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk_w("rst_core_in", core_in, zero);
      rst = 1'b0;

      // Impulse, in_valid held high through WAIT/DRAIN
      send_frame(f_imp, {8{32'h00010000}}, zero, 1'b0, 1'b1);
      drain(1'b0, 8, 1'b0, 32'd0);
      chk_w("core_in_held", core_in, f_imp);

      // DC with backpressure
      send_frame(f_dc, 256'h00080000, zero, 1'b0, 1'b0);
      drain(1'b1, 8, 1'b0, 32'd0);

      // Arbitrary frame against the reference DFT, with backpressure
      send_frame(f_rnd, dft(f_rnd, 1'b0), dft(f_rnd, 1'b1), 1'b0, 1'b0);
      drain(1'b1, 8, 1'b0, 32'd0);

      // Reset after 5 samples
      for (int s = 0; s < 5; s++) send_sample(32'h00030000 + 32'(s), 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rstfill_out_valid", 32'(out_valid), 32'd0);
      chk("rstfill_in_ready", 32'(in_ready), 32'd1);
      chk_w("rstfill_core_in", core_in, zero);
      rst = 1'b0;
      send_frame(f_imp, {8{32'h00010000}}, zero, 1'b0, 1'b0);
      drain(1'b0, 8, 1'b0, 32'd0);

      // Reset while bin 3 is presented
      send_frame(f_imp, {8{32'h00010000}}, zero, 1'b0, 1'b0);
      drain(1'b0, 3, 1'b0, 32'd0);
      chk("pre_rst_idx", 32'(out_idx), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      chk("rstdrain_out_valid", 32'(out_valid), 32'd0);
      chk("rstdrain_in_ready", 32'(in_ready), 32'd1);
      chk("rstdrain_busy", 32'(busy), 32'd0);
      chk_w("rstdrain_core_in", core_in, zero);
      rst = 1'b0;
      sb.delete();
      send_frame(f_imp, {8{32'h00010000}}, zero, 1'b0, 1'b0);
      drain(1'b0, 8, 1'b0, 32'd0);

      // Back-to-back frames with in_valid always high; shifted impulse has exact even bins
      send_frame(f_imp, {8{32'h00010000}}, zero, 1'b0, 1'b1);
      drain(1'b0, 8, 1'b1, 32'd0);
      er = dft(f_sh, 1'b0);
      ei = dft(f_sh, 1'b1);
      er[0*32 +: 32] = 32'h00010000; ei[0*32 +: 32] = 32'h00000000;
      er[2*32 +: 32] = 32'h00000000; ei[2*32 +: 32] = 32'hFFFF0000;
      er[4*32 +: 32] = 32'hFFFF0000; ei[4*32 +: 32] = 32'h00000000;
      er[6*32 +: 32] = 32'h00000000; ei[6*32 +: 32] = 32'h00010000;
      send_frame(f_sh, er, ei, 1'b1, 1'b1);
      drain(1'b1, 8, 1'b0, 32'd0);
      chk_w("core_in_b2b", core_in, f_sh);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
